// File: rtl/vga_fb_arbiter_pkg.sv
// Shared framebuffer geometry and arbiter state encoding.
// Used by the framebuffer arbiter and the renderers that share its write port.
package vga_fb_arbiter_pkg;

  localparam int unsigned H_RES    = 640;
  localparam int unsigned V_RES    = 480;
  localparam int unsigned FB_WORDS = H_RES * V_RES;
  localparam int unsigned FB_AW    = 19;
  localparam int unsigned FB_DW    = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last requester served; search starts at ptr+1
//   grant : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   valid : at least one request present
module vga_fb_arbiter_rr_pick #(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);

  always_comb begin
    logic [31:0]   cand;
    logic [PW-1:0] cidx;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    cidx  = '0;
    // Walk ptr+1, ptr+2, ... ptr+N (mod N) so ptr itself is checked last.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr) + i) % N;
      cidx = PW'(cand);
      if (!valid && req[cidx]) begin
        valid       = 1'b1;
        idx         = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Round-robin burst arbiter for the single VGA framebuffer write port.
//   clk, rstn          : system clock, asynchronous active-low reset
//   req/last           : per-requester write pending / end-of-burst marker
//   addr_in/data_in    : packed per-requester address and data
//   gnt                : registered one-hot burst owner
//   ack                : owner's write accepted this cycle
//   fb_addr/data/wr    : registered framebuffer write port
//   busy               : arbiter is in a burst
//   drop_cnt           : saturating count of out-of-range writes discarded
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned AW        = FB_AW,
  parameter int unsigned DW        = FB_DW,
  parameter int unsigned FB_WORDS  = H_RES * V_RES,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    last,
  input  logic [N_REQ*AW-1:0] addr_in,
  input  logic [N_REQ*DW-1:0] data_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [AW-1:0]       fb_addr,
  output logic [DW-1:0]       fb_data,
  output logic                fb_wr,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  arb_state_e     state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  fb_addr_q, fb_addr_d;
  logic [DW-1:0]  fb_data_q, fb_data_d;
  logic           fb_wr_q, fb_wr_d;
  logic [7:0]     drop_q, drop_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  logic [AW-1:0] owner_addr;
  logic [DW-1:0] owner_data;
  logic          owner_last;
  logic          accepted;
  logic          in_range;

  vga_fb_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Owner index equals ptr_q for the whole burst, so mux the owner's fields by it.
  always_comb begin
    owner_addr = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ptr_q == PW'(i)) begin
        owner_addr = addr_in[i*AW +: AW];
        owner_data = data_in[i*DW +: DW];
      end
    end
  end

  assign owner_last = |(gnt_q & last);
  assign ack        = (state_q == ST_BURST) ? (gnt_q & req) : '0;
  assign accepted   = |ack;
  assign in_range   = 32'(owner_addr) < FB_WORDS;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    fb_wr_d   = 1'b0;
    drop_d    = drop_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (accepted) begin
          cnt_d = cnt_q + CW'(1);
          if (in_range) begin
            fb_wr_d   = 1'b1;
            fb_addr_d = owner_addr;
            fb_data_d = owner_data;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 8'd1;
          end
          if (owner_last || (cnt_q == CW'(BURST_MAX - 1))) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else begin
          // Owner withdrew its request: abandon the burst.
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ptr_q     <= PW'(N_REQ - 1);
      cnt_q     <= '0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      fb_wr_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      fb_wr_q   <= fb_wr_d;
      drop_q    <= drop_d;
    end
  end

  assign gnt      = gnt_q;
  assign fb_addr  = fb_addr_q;
  assign fb_data  = fb_data_q;
  assign fb_wr    = fb_wr_q;
  assign busy     = (state_q == ST_BURST);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter (N_REQ=3, BURST_MAX=16, 640x480).
module tb_vga_fb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [AW-1:0]   fb_addr;
  logic [DW-1:0]   fb_data;
  logic            fb_wr;
  logic            busy;
  logic [7:0]      drop_cnt;

  int unsigned n_chk;
  int unsigned n_bad;

  vga_fb_arbiter #(
    .N_REQ     (3),
    .AW        (19),
    .DW        (16),
    .FB_WORDS  (307200),
    .BURST_MAX (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .last     (last),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .gnt      (gnt),
    .ack      (ack),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_wr    (fb_wr),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic l);
    addr_in[i*AW +: AW] = a;
    data_in[i*DW +: DW] = d;
    last[i]             = l;
  endtask

  // Hold reset across one edge, then release just after an edge.
  task automatic do_reset();
    rstn = 1'b0;
    #2;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rot_exp [4];
    int unsigned  n;
    int unsigned  wr_seen;
    n_chk   = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    req     = '0;
    last    = '0;
    addr_in = '0;
    data_in = '0;

    // 1 Reset with all requests pending
    req = 3'b111;
    for (int i = 0; i < N; i++) set_in(i, AW'(i * 100), DW'(i), 1'b0);
    do_reset();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_ack",  32'(ack), 0);
    chk("rst_wr",   32'(fb_wr), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    tick();
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'b001);

    // 2 Single burst of 4 from requester 0
    req = '0;
    do_reset();
    req = 3'b001;
    set_in(0, 0, 16'h00A0, 1'b0);
    tick();
    chk("single_gnt", 32'(gnt), 32'b001);
    chk("single_wr0", 32'(fb_wr), 0);
    for (int k = 0; k < 4; k++) begin
      set_in(0, AW'(k), DW'(16'h00A0 + k), k == 3);
      #1;
      chk("single_ack", 32'(ack), 32'b001);
      tick();
      chk("single_wr",   32'(fb_wr), 1);
      chk("single_addr", 32'(fb_addr), 32'(k));
      chk("single_data", 32'(fb_data), 32'h00A0 + 32'(k));
      chk("single_gnt_k", 32'(gnt), (k == 3) ? 32'b000 : 32'b001);
    end
    req  = '0;
    last = '0;
    #1;
    chk("single_noack", 32'(ack), 0);
    tick();
    chk("single_wr_end", 32'(fb_wr), 0);
    chk("single_idle",   32'(busy), 0);

    // 3 Forced rotation with all requesters held
    rot_exp[0] = 3'b001;
    rot_exp[1] = 3'b010;
    rot_exp[2] = 3'b100;
    rot_exp[3] = 3'b001;
    req = 3'b111;
    for (int i = 0; i < N; i++) set_in(i, AW'(1000 + i), DW'(i), 1'b0);
    do_reset();
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("rot_gnt", 32'(gnt), 32'(rot_exp[b]));
      n = 0;
      for (int c = 0; c < 40 && gnt == rot_exp[b]; c++) begin
        #1;
        if (ack == rot_exp[b]) n++;
        tick();
      end
      chk("rot_len",  n, 16);
      chk("rot_idle", 32'(gnt), 0);
      tick();
    end
    req = '0;

    // 4 Owner 1 drops request after 5 acks; requester 2 next
    req = 3'b110;
    do_reset();
    tick();
    chk("drop_gnt1", 32'(gnt), 32'b010);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (ack == 3'b010) n++;
      tick();
    end
    chk("drop_acks", n, 5);
    req = 3'b100;
    #1;
    chk("drop_noack", 32'(ack), 0);
    tick();
    chk("drop_idle_gnt", 32'(gnt), 0);
    chk("drop_idle_wr",  32'(fb_wr), 0);
    tick();
    chk("drop_gnt2", 32'(gnt), 32'b100);
    req = '0;

    // 5 Address range and drop counter saturation
    req = '0;
    do_reset();
    req = 3'b001;
    set_in(0, 19'd307199, 16'h1234, 1'b0);
    tick();
    #1;
    chk("rng_ack0", 32'(ack), 32'b001);
    tick();
    chk("rng_wr_ok",   32'(fb_wr), 1);
    chk("rng_addr_ok", 32'(fb_addr), 307199);
    set_in(0, 19'd307200, 16'h5555, 1'b0);
    #1;
    chk("rng_ack1", 32'(ack), 32'b001);
    tick();
    chk("rng_wr_bad",  32'(fb_wr), 0);
    chk("rng_hold_a",  32'(fb_addr), 307199);
    chk("rng_hold_d",  32'(fb_data), 32'h1234);
    chk("rng_drop1",   32'(drop_cnt), 1);
    n       = 0;
    wr_seen = 0;
    for (int c = 0; c < 1000 && n < 300; c++) begin
      #1;
      if (ack[0]) n++;
      tick();
      if (fb_wr) wr_seen++;
    end
    chk("rng_bad_acks", n, 300);
    chk("rng_no_wr",    wr_seen, 0);
    chk("rng_sat",      32'(drop_cnt), 255);
    req = '0;

    // 6 Reset in the middle of a burst
    do_reset();
    req = 3'b001;
    set_in(0, 19'd42, 16'hBEEF, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) tick();
    chk("mid_wr_before", 32'(fb_wr), 1);
    rstn = 1'b0;
    #1;
    chk("mid_wr_rst",   32'(fb_wr), 0);
    chk("mid_gnt_rst",  32'(gnt), 0);
    chk("mid_ack_rst",  32'(ack), 0);
    chk("mid_busy_rst", 32'(busy), 0);
    tick();
    chk("mid_wr_held",  32'(fb_wr), 0);
    rstn = 1'b1;
    tick();
    chk("mid_restart_gnt", 32'(gnt), 32'b001);
    chk("mid_restart_wr",  32'(fb_wr), 0);
    req = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
